// File: rtl/execute_unit_if.sv
// Issue/CDB bundle between the reservation station (master) and the execute unit (slave).
interface execute_unit_if #(
  parameter int DATA_W = 16
);
  logic              flush;
  logic              in_valid;
  logic [3:0]        in_instr_index;
  logic [3:0]        in_opcode;
  logic [7:0]        in_i;
  logic [DATA_W-1:0] in_val1;
  logic [DATA_W-1:0] in_val2;
  logic              cdb_valid;
  logic [3:0]        cdb_rob_index;
  logic [DATA_W-1:0] cdb_result;
  logic              cdb_illegal;
  logic [3:0]        inflight;

  modport master (
    output flush, in_valid, in_instr_index, in_opcode, in_i, in_val1, in_val2,
    input  cdb_valid, cdb_rob_index, cdb_result, cdb_illegal, inflight
  );

  modport slave (
    input  flush, in_valid, in_instr_index, in_opcode, in_i, in_val1, in_val2,
    output cdb_valid, cdb_rob_index, cdb_result, cdb_illegal, inflight
  );
endinterface

// File: rtl/execute_unit.sv
// Fixed-latency integer functional unit: ALU result computed at issue, then delayed
// through LATENCY flop stages onto a CDB slot; flush/reset kill all in-flight ops.
module execute_unit #(
  parameter int LATENCY = 3,
  parameter int DATA_W  = 16
) (
  input logic           clk,
  input logic           rst,
  execute_unit_if.slave bus
);
  logic [DATA_W-1:0] w_result;
  logic              w_illegal;
  logic [3:0]        w_shamt;
  logic [DATA_W-1:0] w_product;
  logic [3:0]        w_count;
  logic              w_valid_next [LATENCY];

  logic              r_valid   [LATENCY];
  logic [3:0]        r_idx     [LATENCY];
  logic [DATA_W-1:0] r_result  [LATENCY];
  logic              r_illegal [LATENCY];
  logic [3:0]        r_inflight;

  assign w_shamt   = bus.in_val2[3:0];
  assign w_product = bus.in_val1 * bus.in_val2;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (bus.in_opcode)
      4'd0:    w_result = bus.in_val1 + bus.in_val2;
      4'd1:    w_result = bus.in_val1 - bus.in_val2;
      4'd2:    w_result = bus.in_val1 & bus.in_val2;
      4'd3:    w_result = bus.in_val1 | bus.in_val2;
      4'd4:    w_result = bus.in_val1 ^ bus.in_val2;
      4'd5:    w_result = bus.in_val1 << w_shamt;
      4'd6:    w_result = bus.in_val1 >> w_shamt;
      4'd7:    w_result = $signed(bus.in_val1) >>> w_shamt;
      4'd8:    w_result = w_product;
      4'd9:    w_result = bus.in_val1 + DATA_W'($signed(bus.in_i));
      4'd10:   w_result = DATA_W'(bus.in_i);
      4'd11:   w_result = DATA_W'({bus.in_i, bus.in_val1[7:0]});
      4'd12:   w_result = {{(DATA_W-1){1'b0}}, ($signed(bus.in_val1) < $signed(bus.in_val2))};
      4'd13:   w_result = {{(DATA_W-1){1'b0}}, (bus.in_val1 < bus.in_val2)};
      default: w_illegal = 1'b1;
    endcase
  end

  // Data fields only load behind a live valid, so bubbles and flushed slots leave
  // the CDB data holding its last value and idle-cycle inputs never leak through.
  genvar gi;
  for (gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic              w_v_in;
    logic [3:0]        w_idx_in;
    logic [DATA_W-1:0] w_res_in;
    logic              w_ill_in;

    if (gi == 0) begin : g_head
      assign w_v_in   = bus.in_valid;
      assign w_idx_in = bus.in_instr_index;
      assign w_res_in = w_result;
      assign w_ill_in = w_illegal;
    end else begin : g_tail
      assign w_v_in   = r_valid[gi-1];
      assign w_idx_in = r_idx[gi-1];
      assign w_res_in = r_result[gi-1];
      assign w_ill_in = r_illegal[gi-1];
    end

    assign w_valid_next[gi] = w_v_in & ~bus.flush;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid[gi]   <= 1'b0;
        r_idx[gi]     <= '0;
        r_result[gi]  <= '0;
        r_illegal[gi] <= 1'b0;
      end else begin
        r_valid[gi]   <= w_valid_next[gi];
        r_illegal[gi] <= w_valid_next[gi] & w_ill_in;
        if (w_valid_next[gi]) begin
          r_idx[gi]    <= w_idx_in;
          r_result[gi] <= w_res_in;
        end
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_count = w_count + {3'b000, w_valid_next[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_count;
    end
  end

  assign bus.cdb_valid     = r_valid[LATENCY-1];
  assign bus.cdb_rob_index = r_idx[LATENCY-1];
  assign bus.cdb_result    = r_result[LATENCY-1];
  assign bus.cdb_illegal   = r_illegal[LATENCY-1];
  assign bus.inflight      = r_inflight;
endmodule

// File: tb/tb_execute_unit.sv
// Directed plus randomized bench for execute_unit against a cycle-stamped queue model.
module tb_execute_unit;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_unit_if #(.DATA_W(16)) bus ();
  execute_unit #(.LATENCY(LAT), .DATA_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          due;
    logic [3:0]  idx;
    logic [15:0] res;
    logic        ill;
  } op_t;

  op_t         pend[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          peak = 0;
  logic [3:0]  hold_idx;
  logic [15:0] hold_res;

  function automatic logic [15:0] ref_alu(input int op, input int imm, input int a, input int b);
    longint r;
    int sa, sb, sh, si;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    sh = b % 16;
    si = (imm >= 128) ? imm - 256 : imm;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = longint'(a) << sh;
      6:  r = a >> sh;
      7:  r = sa >>> sh;
      8:  r = longint'(a) * longint'(b);
      9:  r = a + si;
      10: r = imm;
      11: r = imm * 256 + a % 256;
      12: r = (sa < sb) ? 1 : 0;
      13: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: update the model with the inputs sampled at this edge, then compare.
  task automatic tick();
    op_t  e;
    logic ev;
    cyc++;
    if (rst) begin
      pend.delete();
      hold_idx = '0;
      hold_res = '0;
    end else if (bus.flush) begin
      pend.delete();
    end else if (bus.in_valid) begin
      e.due = cyc + LAT - 1;
      e.idx = bus.in_instr_index;
      e.ill = (bus.in_opcode >= 4'd14);
      e.res = ref_alu(int'(bus.in_opcode), int'(bus.in_i), int'(bus.in_val1), int'(bus.in_val2));
      pend.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    if (ev) begin
      hold_idx = pend[0].idx;
      hold_res = pend[0].res;
    end
    chk("cdb_valid", 32'(bus.cdb_valid), 32'(ev));
    chk("inflight", 32'(bus.inflight), pend.size());
    chk("cdb_rob_index", 32'(bus.cdb_rob_index), 32'(hold_idx));
    chk("cdb_result", 32'(bus.cdb_result), 32'(hold_res));
    if (ev) chk("cdb_illegal", 32'(bus.cdb_illegal), 32'(pend[0].ill));
    else if (rst) chk("cdb_illegal_rst", 32'(bus.cdb_illegal), 32'd0);
    if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
    if (ev) void'(pend.pop_front());
  endtask

  task automatic issue(input logic [3:0] idx, input logic [3:0] op, input logic [7:0] imm,
                       input logic [15:0] v1, input logic [15:0] v2);
    bus.in_valid       = 1'b1;
    bus.in_instr_index = idx;
    bus.in_opcode      = op;
    bus.in_i           = imm;
    bus.in_val1        = v1;
    bus.in_val2        = v2;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid       = 1'b0;
    bus.in_instr_index = 4'($urandom);
    bus.in_opcode      = 4'($urandom);
    bus.in_i           = 8'($urandom);
    bus.in_val1        = 16'($urandom);
    bus.in_val2        = 16'($urandom);
    tick();
  endtask

  task automatic issue_rand();
    issue(4'($urandom), 4'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    // Reset with issue held high
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr_index = 4'd9;
    bus.in_opcode = 4'd0;
    bus.in_i = 8'h11;
    bus.in_val1 = 16'h1234;
    bus.in_val2 = 16'h4321;
    tick();
    tick();
    chk("rst_inflight", 32'(bus.inflight), 32'd0);
    rst = 1'b0;
    idle();

    // ADD with signed wrap, latency 3
    issue(4'd5, 4'd0, 8'h00, 16'h7FFF, 16'h0001);
    idle();
    idle();
    chk("add_valid", 32'(bus.cdb_valid), 32'd1);
    chk("add_idx", 32'(bus.cdb_rob_index), 32'd5);
    chk("add_result", 32'(bus.cdb_result), 32'h8000);
    idle();
    chk("add_one_cycle", 32'(bus.cdb_valid), 32'd0);
    chk("add_hold", 32'(bus.cdb_result), 32'h8000);

    // Back-to-back MUL, ADDI, SLT
    issue(4'd1, 4'd8,  8'hFE, 16'hFFFF, 16'h0002);
    issue(4'd2, 4'd9,  8'hFE, 16'hFFFF, 16'h0002);
    issue(4'd3, 4'd12, 8'hFE, 16'hFFFF, 16'h0002);
    chk("mul_result", 32'(bus.cdb_result), 32'hFFFE);
    idle();
    chk("addi_result", 32'(bus.cdb_result), 32'hFFFD);
    idle();
    chk("slt_result", 32'(bus.cdb_result), 32'h0001);
    chk("slt_idx", 32'(bus.cdb_rob_index), 32'd3);
    idle();

    // Shift and immediate forms
    issue(4'd1, 4'd7,  8'h00, 16'h8000, 16'h0004);
    issue(4'd2, 4'd10, 8'hAB, 16'hFFFF, 16'hFFFF);
    issue(4'd3, 4'd11, 8'h12, 16'h0034, 16'h0000);
    chk("sra_result", 32'(bus.cdb_result), 32'hF800);
    idle();
    chk("movi_result", 32'(bus.cdb_result), 32'h00AB);
    idle();
    chk("lui_result", 32'(bus.cdb_result), 32'h1234);
    idle();

    // Flush alongside the third issue
    issue(4'd10, 4'd0, 8'h00, 16'h0001, 16'h0001);
    issue(4'd11, 4'd0, 8'h00, 16'h0002, 16'h0002);
    bus.flush = 1'b1;
    issue(4'd12, 4'd0, 8'h00, 16'h0003, 16'h0003);
    bus.flush = 1'b0;
    chk("flush_valid", 32'(bus.cdb_valid), 32'd0);
    chk("flush_inflight", 32'(bus.inflight), 32'd0);
    idle();
    idle();
    chk("flush_none_out", 32'(bus.cdb_valid), 32'd0);
    issue(4'd4, 4'd0, 8'h00, 16'h0001, 16'h0002);
    idle();
    idle();
    chk("post_flush_valid", 32'(bus.cdb_valid), 32'd1);
    chk("post_flush_result", 32'(bus.cdb_result), 32'h0003);
    idle();

    // Reserved opcode under continuous issue
    peak = 0;
    issue(4'd7, 4'd15, 8'h55, 16'hAAAA, 16'h5555);
    issue_rand();
    issue_rand();
    chk("illegal_valid", 32'(bus.cdb_valid), 32'd1);
    chk("illegal_flag", 32'(bus.cdb_illegal), 32'd1);
    chk("illegal_idx", 32'(bus.cdb_rob_index), 32'd7);
    chk("illegal_result", 32'(bus.cdb_result), 32'h0000);
    chk("inflight_full", 32'(bus.inflight), 32'd3);
    for (int n = 0; n < 10; n++) issue_rand();
    chk("inflight_peak", 32'(peak), 32'd3);

    // Reset mid-operation discards in-flight work
    issue(4'd6, 4'd0, 8'h00, 16'h0010, 16'h0020);
    rst = 1'b1;
    issue(4'd8, 4'd0, 8'h00, 16'h0030, 16'h0040);
    rst = 1'b0;
    chk("midrst_result", 32'(bus.cdb_result), 32'h0000);
    for (int n = 0; n < 4; n++) idle();

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) != 0) issue_rand();
      else idle();
    end
    rst = 1'b0;
    bus.flush = 1'b0;
    for (int n = 0; n < LAT + 2; n++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
